csel_mp_add_seq: RTL

- Multi-precision add/subtract sequencer built on a single 16-bit carry-select adder slice.
- Per cycle, the slice computes one 16-bit word, least significant first, and the carry is chained through a register between cycles.
- Operands of WORDS×16 bits arrive with a valid/ready handshake; the result leaves with a second valid/ready handshake.
- Used wherever wide additions (64-bit and above) must share one narrow adder datapath instead of replicating it.

---
 rtl/csel_mp_add_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/csel_mp_add_seq.sv
// Multi-precision add/subtract sequencer: one 16-bit carry-select slice processes
// a WORDS*16-bit operation one word per cycle, least significant word first.
module csel_mp_add_seq #(
  parameter int WORDS = 4,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int W = 16 * WORDS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     op_a, op_b;
  logic             carry;
  logic [CNT_W-1:0] idx;
  logic [15:0]      wa, wb, slice_sum;
  logic             slice_co;
  logic             accept, last;

  function automatic logic [4:0] rca4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c);
    logic [4:0] r;
    logic       cc;
    r  = '0;
    cc = c;
    for (int i = 0; i < 4; i++) begin
      r[i] = x[i] ^ y[i] ^ cc;
      cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
    end
    r[4] = cc;
    return r;
  endfunction

  // Word select for the current index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wa = '0;
    wb = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx == CNT_W'(w)) begin
        wa = op_a[16*w +: 16];
        wb = op_b[16*w +: 16];
      end
    end
  end

  // Upper nibbles are precomputed for both carries and picked by the nibble below.
  always_comb begin : slice
    logic [4:0] lo, hi0, hi1;
    logic       c;
    lo        = rca4(wa[3:0], wb[3:0], carry);
    hi0       = '0;
    hi1       = '0;
    slice_sum = '0;
    slice_sum[3:0] = lo[3:0];
    c         = lo[4];
    for (int j = 1; j < 4; j++) begin
      hi0 = rca4(wa[4*j +: 4], wb[4*j +: 4], 1'b0);
      hi1 = rca4(wa[4*j +: 4], wb[4*j +: 4], 1'b1);
      slice_sum[4*j +: 4] = c ? hi1[3:0] : hi0[3:0];
      c = c ? hi1[4] : hi0[4];
    end
    slice_co = c;
  end

  assign last = (idx == CNT_W'(WORDS - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a  <= a;
        op_b  <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        idx   <= '0;
      end else if (state == RUN) begin
        for (int w = 0; w < WORDS; w++) begin
          if (idx == CNT_W'(w)) sum[16*w +: 16] <= slice_sum;
        end
        carry <= slice_co;
        idx   <= idx + CNT_W'(1);
        if (last) begin
          cout <= slice_co;
          // op_b already holds ~b in subtract mode, so one rule covers both.
          ovf  <= (op_a[W-1] == op_b[W-1]) & (slice_sum[15] != op_a[W-1]);
        end
      end
    end
  end

endmodule
